// File: rtl/vga_sync_gen_if.sv
// VGA timing bundle: pixel strobe, raster position, blanking and sync levels
// from the timing generator to its downstream consumers.
interface vga_sync_gen_if;
   logic       p_tick;
   logic [9:0] pixel_x;
   logic [9:0] pixel_y;
   logic       video_on;
   logic       hsync;
   logic       vsync;
   logic       frame_start;

   modport master (
      output p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_start
   );
   modport slave (
      input  p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_start
   );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel-rate divider, h/v counters, registered
// sync pulses aligned with the counters, and a one-clock frame-start pulse.
module vga_sync_gen #(
   parameter int unsigned CLK_DIV     = 2,
   parameter int unsigned H_DISP      = 640,
   parameter int unsigned H_FP        = 16,
   parameter int unsigned H_SYNC      = 96,
   parameter int unsigned H_BP        = 48,
   parameter int unsigned V_DISP      = 480,
   parameter int unsigned V_FP        = 10,
   parameter int unsigned V_SYNC      = 2,
   parameter int unsigned V_BP        = 33,
   parameter bit          SYNC_ACTIVE = 1'b0
) (
   input  logic           i_clk,
   input  logic           i_reset,
   vga_sync_gen_if.master vga
);
   localparam int unsigned H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
   localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
   localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS        = 10'(H_DISP);
   localparam logic [9:0] V_VIS        = 10'(V_DISP);
   localparam logic [9:0] H_SYNC_FIRST = 10'(H_DISP + H_FP);
   localparam logic [9:0] H_SYNC_LAST  = 10'(H_DISP + H_FP + H_SYNC - 1);
   localparam logic [9:0] V_SYNC_FIRST = 10'(V_DISP + V_FP);
   localparam logic [9:0] V_SYNC_LAST  = 10'(V_DISP + V_FP + V_SYNC - 1);

   logic [DIV_W-1:0] r_div_cnt, w_div_nxt;
   logic [9:0]       r_h_cnt, r_v_cnt, w_h_nxt, w_v_nxt;
   logic             r_hsync, r_vsync, r_frame_start;
   logic             w_p_tick, w_h_wrap, w_v_wrap, w_hsync_act, w_vsync_act;

   assign w_p_tick = (r_div_cnt == DIV_LAST);
   assign w_h_wrap = w_p_tick && (r_h_cnt == H_LAST);
   assign w_v_wrap = w_h_wrap && (r_v_cnt == V_LAST);

   always_comb begin
      w_div_nxt = w_p_tick ? '0 : r_div_cnt + DIV_ONE;
      w_h_nxt   = r_h_cnt;
      w_v_nxt   = r_v_cnt;
      if (w_p_tick) w_h_nxt = w_h_wrap ? '0 : r_h_cnt + 10'd1;
      if (w_h_wrap) w_v_nxt = w_v_wrap ? '0 : r_v_cnt + 10'd1;
   end

   // Syncs decode the next-state counters so the registered level lines up with pixel_x/y.
   assign w_hsync_act = (w_h_nxt >= H_SYNC_FIRST) && (w_h_nxt <= H_SYNC_LAST);
   assign w_vsync_act = (w_v_nxt >= V_SYNC_FIRST) && (w_v_nxt <= V_SYNC_LAST);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_div_cnt     <= '0;
         r_h_cnt       <= '0;
         r_v_cnt       <= '0;
         r_hsync       <= ~SYNC_ACTIVE;
         r_vsync       <= ~SYNC_ACTIVE;
         r_frame_start <= 1'b0;
      end else begin
         r_div_cnt     <= w_div_nxt;
         r_h_cnt       <= w_h_nxt;
         r_v_cnt       <= w_v_nxt;
         r_hsync       <= w_hsync_act ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         r_vsync       <= w_vsync_act ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         r_frame_start <= w_v_wrap;
      end
   end

   assign vga.p_tick      = w_p_tick;
   assign vga.pixel_x     = r_h_cnt;
   assign vga.pixel_y     = r_v_cnt;
   assign vga.video_on    = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
   assign vga.hsync       = r_hsync;
   assign vga.vsync       = r_vsync;
   assign vga.frame_start = r_frame_start;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default timing, a shrunken raster for frame-level
// behaviour, and a CLK_DIV=1 / active-high-sync variant, all against a closed-form model.
module tb_vga_sync_gen;
   typedef struct packed {
      logic       p_tick;
      logic [9:0] x;
      logic [9:0] y;
      logic       video_on;
      logic       hsync;
      logic       vsync;
      logic       frame_start;
   } obs_t;

   logic clk = 1'b0;
   logic i_reset = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   int   k = 0;
   int   fs_prev = -1;
   int   n_fs_periods = 0;
   int   hs0_low = 0;
   int   hs2_high = 0;
   obs_t q0[$], q1[$], q2[$];

   always #10 clk = ~clk;

   vga_sync_gen_if vga0 ();
   vga_sync_gen_if vga1 ();
   vga_sync_gen_if vga2 ();

   vga_sync_gen u_dut0 (.i_clk(clk), .i_reset(i_reset), .vga(vga0));

   vga_sync_gen #(
      .CLK_DIV(2), .H_DISP(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_DISP(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_ACTIVE(1'b0)
   ) u_dut1 (.i_clk(clk), .i_reset(i_reset), .vga(vga1));

   vga_sync_gen #(
      .CLK_DIV(1), .SYNC_ACTIVE(1'b1)
   ) u_dut2 (.i_clk(clk), .i_reset(i_reset), .vga(vga2));

   // State after kc clock edges since the reset edge, from tick count alone.
   function automatic obs_t model(int kc, int d, int hd, int hf, int hs, int hb,
                                  int vd, int vf, int vs, int vb, bit act);
      obs_t m;
      int ht, vt, n, h, v;
      ht = hd + hf + hs + hb;
      vt = vd + vf + vs + vb;
      n  = kc / d;
      h  = n % ht;
      v  = (n / ht) % vt;
      m.p_tick      = ((kc % d) == d - 1);
      m.x           = 10'(h);
      m.y           = 10'(v);
      m.video_on    = (h < hd) && (v < vd);
      m.hsync       = (h >= hd + hf && h < hd + hf + hs) ? act : !act;
      m.vsync       = (v >= vd + vf && v < vd + vf + vs) ? act : !act;
      m.frame_start = ((kc % d) == 0) && (n > 0) && ((n % (ht * vt)) == 0);
      return m;
   endfunction

   task automatic check(input string tag, input obs_t obs, input obs_t exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s k=%0d obs(tick=%b x=%0d y=%0d von=%b hs=%b vs=%b fs=%b) exp(tick=%b x=%0d y=%0d von=%b hs=%b vs=%b fs=%b)",
                tag, k, obs.p_tick, obs.x, obs.y, obs.video_on, obs.hsync, obs.vsync,
                obs.frame_start, exp.p_tick, exp.x, exp.y, exp.video_on, exp.hsync,
                exp.vsync, exp.frame_start);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input bit rst);
      obs_t o0, o1, o2;
      i_reset = rst;
      @(posedge clk);
      if (rst) k = 0;
      else k++;
      q0.push_back(model(k, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
      q1.push_back(model(k, 2, 16, 2, 3, 3, 8, 2, 2, 3, 1'b0));
      q2.push_back(model(k, 1, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1));
      @(negedge clk);
      o0 = {vga0.p_tick, vga0.pixel_x, vga0.pixel_y, vga0.video_on, vga0.hsync,
            vga0.vsync, vga0.frame_start};
      o1 = {vga1.p_tick, vga1.pixel_x, vga1.pixel_y, vga1.video_on, vga1.hsync,
            vga1.vsync, vga1.frame_start};
      o2 = {vga2.p_tick, vga2.pixel_x, vga2.pixel_y, vga2.video_on, vga2.hsync,
            vga2.vsync, vga2.frame_start};
      check("dut0_default", o0, q0.pop_front());
      check("dut1_small", o1, q1.pop_front());
      check("dut2_div1_pos", o2, q2.pop_front());
      if (rst) begin
         fs_prev  = -1;
         hs0_low  = 0;
         hs2_high = 0;
      end else begin
         if (k <= 1600 && o0.hsync === 1'b0) hs0_low++;
         if (k <= 800 && o2.hsync === 1'b1) hs2_high++;
         if (o1.frame_start === 1'b1) begin
            // 24 x 15 raster at two clocks per tick
            if (fs_prev >= 0) begin
               check_int("small_frame_period", k - fs_prev, 720);
               n_fs_periods++;
            end
            fs_prev = k;
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 5; i++) tick(1'b1);
      for (int i = 0; i < 3300; i++) tick(1'b0);
      check_int("hsync0_low_clks_line0", hs0_low, 192);
      check_int("hsync2_high_clks_line0", hs2_high, 96);
      check_int("small_frame_periods_seen", (n_fs_periods > 0) ? 1 : 0, 1);

      // Land on (300,2) of the default raster, then a one-clock mid-line reset.
      while (k < 3800) tick(1'b0);
      tick(1'b1);
      n_fs_periods = 0;
      for (int i = 0; i < 2000; i++) tick(1'b0);
      check_int("hsync0_low_clks_after_reset", hs0_low, 192);
      check_int("hsync2_high_clks_after_reset", hs2_high, 96);
      check_int("small_frame_periods_after_reset", (n_fs_periods > 0) ? 1 : 0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Generates VGA 640x480 @ 60 Hz timing from the 50 MHz board clock.
- Sits directly upstream of the rectangle/object generators and the RGB mux.
- Supplies pixel_x/pixel_y, which those generators compare against their bounds to assert their *_on flags.
- Supplies video_on, which the RGB mux uses to blank output, and hsync/vsync, which drive the VGA connector.

Parameters:
- CLK_DIV, 2, system clocks per pixel; p_tick is asserted once every CLK_DIV clocks.
- H_DISP, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, horizontal sync width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_DISP, 480, visible lines per frame.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vertical sync width in lines.
- V_BP, 33, vertical back porch in lines.
- SYNC_ACTIVE, 0, level of hsync/vsync during the sync pulse (0 = active-low).

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- p_tick  out  1  one-clk pixel-enable strobe.
- pixel_x  out  10  current horizontal count, 0..H_TOTAL-1.
- pixel_y  out  10  current vertical count, 0..V_TOTAL-1.
- video_on  out  1  high when pixel_x < H_DISP and pixel_y < V_DISP.
- hsync  out  1  horizontal sync, registered.
- vsync  out  1  vertical sync, registered.
- frame_start  out  1  one-clk pulse when the counters wrap to (0,0).

Behaviour:
- Derived constants: H_TOTAL = H_DISP+H_FP+H_SYNC+H_BP = 800; V_TOTAL = V_DISP+V_FP+V_SYNC+V_BP = 525.
- Tick divider: mod-CLK_DIV counter div_cnt. p_tick = (div_cnt == CLK_DIV-1), combinational from the register. With CLK_DIV=1, p_tick is constantly 1 outside reset.
- Horizontal counter h_cnt: advances only on a clock where p_tick=1. At H_TOTAL-1 it wraps to 0, otherwise it increments.
- Vertical counter v_cnt: advances only when p_tick=1 and h_cnt=H_TOTAL-1. At V_TOTAL-1 it wraps to 0, otherwise it increments.
- Outputs: pixel_x = h_cnt, pixel_y = v_cnt, driven directly from registers with zero latency.
- video_on: combinational from h_cnt/v_cnt.
- hsync register: loaded each clk from the next-state h_cnt value so it is aligned with pixel_x (no extra lag).
  - Equals SYNC_ACTIVE when H_DISP+H_FP <= h_cnt <= H_DISP+H_FP+H_SYNC-1 (656..751).
  - Otherwise equals ~SYNC_ACTIVE.
- vsync register: same scheme against v_cnt, active for V_DISP+V_FP <= v_cnt <= V_DISP+V_FP+V_SYNC-1 (490..491).
- frame_start: registered. Asserted for exactly one clk, the clk on which h_cnt and v_cnt both become 0 through wrap. Never asserted by reset.
- Reset (synchronous, active-high), takes effect at the clk edge, including mid-line or mid-frame:
  - div_cnt=0, h_cnt=0, v_cnt=0, frame_start=0.
  - hsync=~SYNC_ACTIVE, vsync=~SYNC_ACTIVE.
  - Hence p_tick=0 for CLK_DIV>1, video_on=1 at (0,0), pixel_x=pixel_y=0.
- After reset release, the first p_tick occurs CLK_DIV-1 clks later. The counters hold their values between ticks.
- Simultaneous horizontal and vertical wrap (h=799, v=524, p_tick=1): both go to 0 on the same edge and frame_start pulses on that edge.
- Widths: counters are 10 bits; H_TOTAL and V_TOTAL must be <= 1024. No counter saturates; all wrap only as specified.
- Line period 800 ticks (1600 clks at CLK_DIV=2). Frame period 420000 ticks (840000 clks).

Test Plan:
- Hold reset 5 clks, release → pixel_x=0, pixel_y=0, hsync=vsync=1, video_on=1, frame_start=0; first p_tick on the 2nd clk after release, then every 2 clks.
- Run one line → pixel_x steps 0..799 once per p_tick, then wraps to 0 and pixel_y becomes 1.
  - hsync=0 exactly while pixel_x=656..751 (96 ticks = 192 clks).
  - video_on falls when pixel_x goes 639→640.
- Run one frame → vsync=0 exactly for lines 490..491 (1600 ticks). video_on=0 for all of lines 480..524.
- Frame wrap: at (799,524) on p_tick → next clk (0,0) with frame_start=1 for one clk. Next frame_start comes exactly 840000 clks later.
- Assert reset for 1 clk at (300,200) → next clk (0,0), hsync=vsync=1, frame_start stays 0. Counting then resumes per the reset-release case.
- Parameter override CLK_DIV=1, SYNC_ACTIVE=1 → p_tick high every clk; hsync=1 only for pixel_x 656..751; line period 800 clks.
